// File: rtl/operand_encoder.sv
// Button-driven hex operand entry: debounced push buttons edit a 32-bit word
// nibble by nibble and commit it to the Calculator on a center press.

// Purpose: 2-flop synchronizer, counter debounce and rising-edge detect for one button.
// Latency: press pulse is high in the cycle after 2 + DEBOUNCE_CYCLES edges of a stable input.
// Backpressure: none; pulses are single-cycle and are not held or queued.
module operand_encoder_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic IN_clk,
    input  logic IN_reset_n,
    input  logic IN_raw,
    output logic OUT_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge IN_clk or negedge IN_reset_n) begin
        if (!IN_reset_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= IN_raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Any cycle where the input agrees with the accepted level restarts the count.
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign OUT_press = r_level & ~r_level_d;

endmodule

// Purpose: edit an 8-nibble working word with up/down/left/right, commit on center.
// Latency: edits land 2 + DEBOUNCE_CYCLES + 1 edges after a clean press; valid pulses one cycle.
// Backpressure: none; one event per cycle, center > up > down > left > right, losers dropped.
module operand_encoder #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        IN_clk,
    input  logic        IN_reset_n,
    input  logic        IN_up_button,
    input  logic        IN_down_button,
    input  logic        IN_left_button,
    input  logic        IN_right_button,
    input  logic        IN_center_button,
    output logic [31:0] OUT_binary_operand,
    output logic        OUT_operand_valid,
    output logic [2:0]  OUT_cursor,
    output logic [7:0]  OUT_Led_Visualizer,
    output logic [3:0]  OUT_EntryDigit0,
    output logic [3:0]  OUT_EntryDigit1,
    output logic [3:0]  OUT_EntryDigit2,
    output logic [3:0]  OUT_EntryDigit3
);

    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTER = 4;

    logic [4:0]  w_raw;
    logic [4:0]  w_press;
    logic [3:0]  w_nibble;
    logic [15:0] w_window;

    logic [31:0] r_work;
    logic [2:0]  r_cursor;
    logic [31:0] r_operand;
    logic        r_valid;

    assign w_raw = {IN_center_button, IN_right_button, IN_left_button,
                    IN_down_button, IN_up_button};

    for (genvar g = 0; g < 5; g++) begin : g_btn
        operand_encoder_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .IN_clk     (IN_clk),
            .IN_reset_n (IN_reset_n),
            .IN_raw     (w_raw[g]),
            .OUT_press  (w_press[g])
        );
    end

    assign w_nibble = r_work[{r_cursor, 2'b00} +: 4];

    always_ff @(posedge IN_clk or negedge IN_reset_n) begin
        if (!IN_reset_n) begin
            r_work    <= '0;
            r_cursor  <= '0;
            r_operand <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_press[BTN_CENTER]) begin
                r_operand <= r_work;
                r_valid   <= 1'b1;
                r_work    <= '0;
                r_cursor  <= '0;
            end else if (w_press[BTN_UP]) begin
                // Nibble-local wrap: no carry into the neighbouring digit.
                r_work[{r_cursor, 2'b00} +: 4] <= w_nibble + 4'd1;
            end else if (w_press[BTN_DOWN]) begin
                r_work[{r_cursor, 2'b00} +: 4] <= w_nibble - 4'd1;
            end else if (w_press[BTN_LEFT]) begin
                r_cursor <= r_cursor + 3'd1;
            end else if (w_press[BTN_RIGHT]) begin
                r_cursor <= r_cursor - 3'd1;
            end
        end
    end

    // The display shows the 4-digit half of the word that contains the cursor.
    assign w_window = r_cursor[2] ? r_work[31:16] : r_work[15:0];

    assign OUT_binary_operand = r_operand;
    assign OUT_operand_valid  = r_valid;
    assign OUT_cursor         = r_cursor;
    assign OUT_Led_Visualizer = 8'd1 << r_cursor;
    assign OUT_EntryDigit0    = w_window[3:0];
    assign OUT_EntryDigit1    = w_window[7:4];
    assign OUT_EntryDigit2    = w_window[11:8];
    assign OUT_EntryDigit3    = w_window[15:12];

endmodule

// File: doc/operand_encoder.md
OPERAND_ENCODER -- requirements
Module: operand_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning consecutive stable cycles needed before a button level is accepted (minimum 1).
REQ-002 SHALL have port IN_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port IN_reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports IN_up_button, IN_down_button, IN_left_button, IN_right_button, IN_center_button  input  1 each  raw asynchronous push buttons, active-high.
REQ-005 SHALL have port OUT_binary_operand  output  32  last committed operand for the Calculator.
REQ-006 SHALL have port OUT_operand_valid  output  1  one-cycle pulse marking a new OUT_binary_operand.
REQ-007 SHALL have port OUT_cursor  output  3  index (0..7) of the hex digit being edited.
REQ-008 SHALL have port OUT_Led_Visualizer  output  8  one-hot cursor indicator.
REQ-009 SHALL have ports OUT_EntryDigit0, OUT_EntryDigit1, OUT_EntryDigit2, OUT_EntryDigit3  output  4 each  nibbles of the displayed 4-digit window, fed to the existing seven-segment decoder.

Function
REQ-010 SHALL pass each button through a 2-flop synchronizer before any other logic.
REQ-011 SHALL debounce each button independently: debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap restarts that button's counter.
REQ-012 SHALL generate a one-cycle press event on each debounced 0->1 transition; release and held levels generate no events.
REQ-013 SHALL hold a 32-bit working register W (8 nibbles, nibble 0 = bits 3:0) and a 3-bit cursor C.
REQ-014 SHALL on an up event set W nibble C to (nibble+1) mod 16, no carry into other nibbles (F->0).
REQ-015 SHALL on a down event set W nibble C to (nibble-1) mod 16, no borrow (0->F).
REQ-016 SHALL on a left event set C to C+1 mod 8 (7->0), and on a right event set C to C-1 mod 8 (0->7).
REQ-017 SHALL on a center event, in the same clock edge, load OUT_binary_operand with W, set OUT_operand_valid to 1 for exactly that following cycle, clear W to 0 and C to 0.
REQ-018 SHALL act on at most one event per cycle with priority center > up > down > left > right; lower-priority events in the same cycle are discarded, not queued.
REQ-019 SHALL keep OUT_operand_valid low in every cycle not immediately following a center event.
REQ-020 SHALL drive OUT_cursor = C and OUT_Led_Visualizer = 1 << C combinationally from registered C.
REQ-021 SHALL select window base B = 4 when C >= 4, else B = 0, and drive OUT_EntryDigitk = W nibble (B+k), k = 0..3, combinationally from registered W.
REQ-022 SHALL hold OUT_binary_operand unchanged between commits, regardless of edits to W.
REQ-023 SHALL produce a register update exactly 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) cycles after a clean press reaches the input, with outputs visible the following cycle.

Reset
REQ-024 SHALL while IN_reset_n is low, asynchronously force W = 0, C = 0, OUT_binary_operand = 0, OUT_operand_valid = 0, all synchronizer flops, debounced levels and counters to 0.
REQ-025 SHALL consequently reset OUT_Led_Visualizer = 8'b00000001, OUT_cursor = 0, all OUT_EntryDigit = 0.
REQ-026 SHALL discard any partially debounced press when reset asserts mid-count; a button held through reset release registers one press after full DEBOUNCE_CYCLES.

Verification (bench uses DEBOUNCE_CYCLES = 4)
REQ-027 SHALL cover: reset, press up 3 times, left once, up once, center -> OUT_binary_operand = 32'h00000013, one-cycle OUT_operand_valid, then W = 0, LED = 8'h01.
REQ-028 SHALL cover: down at reset state -> nibble 0 = F, OUT_EntryDigit0 = 4'hF, other digits 0; right once -> C = 7, LED = 8'h80, window shows nibbles 4..7.
REQ-029 SHALL cover: 3-cycle glitch on IN_up_button -> no change to W; 6-cycle clean pulse -> exactly one increment.
REQ-030 SHALL cover: center and up debounced rising on same cycle -> commit of pre-edit W only, up discarded, W = 0 afterward.
REQ-031 SHALL cover: IN_reset_n low mid-debounce of left and for one cycle after a commit -> all outputs at reset values immediately, no LED move or valid pulse after release.
REQ-032 SHALL cover: 16 up presses on one nibble -> nibble wraps back to 0, adjacent nibble unchanged, OUT_binary_operand unchanged throughout.
